// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-port frame RAM.
package dp_ram_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  localparam int unsigned RD_LAT_1 = 1;
  localparam int unsigned RD_LAT_2 = 2;

endpackage

// File: rtl/dp_ram_core.sv
// True dual-port byte-enabled storage array: one clock, no reset, registered reads.
// Reads return the pre-edge contents; on an address collision port a's lanes land last.
module dp_ram_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 307200,
  parameter int unsigned IDX_W      = 19
) (
  input  logic                      clk,
  input  logic                      a_we,
  input  logic                      a_re,
  input  logic [IDX_W-1:0]          a_addr,
  input  logic [DATA_WIDTH-1:0]     a_wdata,
  input  logic [DATA_WIDTH/8-1:0]   a_be,
  output logic [DATA_WIDTH-1:0]     a_rdata,
  input  logic                      b_we,
  input  logic                      b_re,
  input  logic [IDX_W-1:0]          b_addr,
  input  logic [DATA_WIDTH-1:0]     b_wdata,
  input  logic [DATA_WIDTH/8-1:0]   b_be,
  output logic [DATA_WIDTH-1:0]     b_rdata
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array access for both ports; port a writes are ordered after port b
  always_ff @(posedge clk) begin
    if (a_re) a_rdata <= mem[a_addr];
    if (b_re) b_rdata <= mem[b_addr];
    for (int i = 0; i < int'(BE_W); i++) begin
      if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dual_port_frame_ram.sv
// Dual-port frame RAM: two Avalon-MM slaves, byte enables, 1/2-cycle read
// latency, and a fill engine that paints the whole array through port 2.
module dual_port_frame_ram
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned DEPTH        = 307200,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  s1_address,
  input  logic                   s1_chipselect,
  input  logic                   s1_read,
  input  logic                   s1_write,
  input  logic [DATA_WIDTH-1:0]  s1_writedata,
  input  logic [BE_WIDTH-1:0]    s1_byteenable,
  output logic [DATA_WIDTH-1:0]  s1_readdata,
  output logic                   s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]  s2_address,
  input  logic                   s2_chipselect,
  input  logic                   s2_read,
  input  logic                   s2_write,
  input  logic [DATA_WIDTH-1:0]  s2_writedata,
  input  logic [BE_WIDTH-1:0]    s2_byteenable,
  output logic [DATA_WIDTH-1:0]  s2_readdata,
  output logic                   s2_readdatavalid,
  output logic                   s2_waitrequest,
  input  logic                   fill_start,
  input  logic [DATA_WIDTH-1:0]  fill_value,
  output logic                   fill_busy,
  output logic                   fill_done
);

  localparam int unsigned          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]  DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < DEPTH_EXT);
  endfunction

  fill_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic [DATA_WIDTH-1:0] fill_q, fill_next;
  logic                  busy_q, done_q;

  logic s1_wr, s1_rd, s1_wr_hit, s1_rd_hit;
  logic s2_acc, s2_wr, s2_rd, s2_rd_hit;

  logic                  p2_wr_req, p2_we;
  logic [ADDR_WIDTH-1:0] p2_addr;
  logic [DATA_WIDTH-1:0] p2_data;
  logic [BE_WIDTH-1:0]   p2_be;

  logic [DATA_WIDTH-1:0] s1_q, s2_q;
  logic                  s1_v1, s1_h1, s2_v1, s2_h1;

  // Access decode: write has priority over read on the same port
  assign s1_wr     = s1_chipselect & s1_write;
  assign s1_rd     = s1_chipselect & s1_read & ~s1_write;
  assign s1_wr_hit = s1_wr & in_range(s1_address);
  assign s1_rd_hit = s1_rd & in_range(s1_address);

  assign s2_acc    = s2_chipselect & ~busy_q;
  assign s2_wr     = s2_acc & s2_write;
  assign s2_rd     = s2_acc & s2_read & ~s2_write;
  assign s2_rd_hit = s2_rd & in_range(s2_address);

  // Port 2 datapath mux: fill engine owns the write side while running
  always_comb begin
    p2_wr_req = s2_wr;
    p2_addr   = s2_address;
    p2_data   = s2_writedata;
    p2_be     = s2_byteenable;
    if (state == FILL_RUN) begin
      p2_wr_req = 1'b1;
      p2_addr   = cnt;
      p2_data   = fill_q;
      p2_be     = '1;
    end
  end

  // Port 1 wins a same-address write collision
  assign p2_we = p2_wr_req & in_range(p2_addr) & ~(s1_wr_hit & (s1_address == p2_addr));

  dp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk     (clk),
    .a_we    (s1_wr_hit),
    .a_re    (s1_rd_hit),
    .a_addr  (s1_address[IDX_W-1:0]),
    .a_wdata (s1_writedata),
    .a_be    (s1_byteenable),
    .a_rdata (s1_q),
    .b_we    (p2_we),
    .b_re    (s2_rd_hit),
    .b_addr  (p2_addr[IDX_W-1:0]),
    .b_wdata (p2_data),
    .b_be    (p2_be),
    .b_rdata (s2_q)
  );

  // Fill FSM next-state logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fill_next  = fill_q;
    case (state)
      FILL_IDLE: begin
        if (fill_start) begin
          state_next = FILL_RUN;
          cnt_next   = '0;
          fill_next  = fill_value;
        end
      end
      FILL_RUN: begin
        cnt_next = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_ADDR) state_next = FILL_DONE;
      end
      FILL_DONE: state_next = FILL_IDLE;
      default:   state_next = FILL_IDLE;
    endcase
  end

  // Fill FSM state, counter, captured value and registered status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL_IDLE;
      cnt    <= '0;
      fill_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      fill_q <= fill_next;
      busy_q <= (state_next != FILL_IDLE);
      done_q <= (state_next == FILL_DONE);
    end
  end

  assign fill_busy      = busy_q;
  assign s2_waitrequest = busy_q;
  assign fill_done      = done_q;

  // First read stage: beat valid and in-range flag alongside the array read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v1 <= 1'b0;
      s1_h1 <= 1'b0;
      s2_v1 <= 1'b0;
      s2_h1 <= 1'b0;
    end else begin
      s1_v1 <= s1_rd;
      s1_h1 <= s1_rd_hit;
      s2_v1 <= s2_rd;
      s2_h1 <= s2_rd_hit;
    end
  end

  if (READ_LATENCY == RD_LAT_2) begin : g_lat2
    logic                  s1_v2, s2_v2;
    logic [DATA_WIDTH-1:0] s1_d2, s2_d2;

    // Extra output register stage
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_v2 <= 1'b0;
        s2_v2 <= 1'b0;
        s1_d2 <= '0;
        s2_d2 <= '0;
      end else begin
        s1_v2 <= s1_v1;
        s2_v2 <= s2_v1;
        s1_d2 <= s1_h1 ? s1_q : '0;
        s2_d2 <= s2_h1 ? s2_q : '0;
      end
    end

    assign s1_readdata      = s1_d2;
    assign s1_readdatavalid = s1_v2;
    assign s2_readdata      = s2_d2;
    assign s2_readdatavalid = s2_v2;
  end else begin : g_lat1
    // Out-of-range or idle beats read as zero
    assign s1_readdata      = s1_h1 ? s1_q : '0;
    assign s1_readdatavalid = s1_v1;
    assign s2_readdata      = s2_h1 ? s2_q : '0;
    assign s2_readdatavalid = s2_v1;
  end

endmodule

// File: tb/tb_dual_port_frame_ram.sv
// Bench for dual_port_frame_ram: latency-1 and latency-2 instances share stimulus
// and are compared against an array-based reference model each cycle.
module tb_dual_port_frame_ram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DP = 16;
  localparam int unsigned BW = 4;

  logic clk;
  logic rst_n;

  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic          s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic          fill_start;
  logic [DW-1:0] fill_value;

  logic [DW-1:0] l1_s1_rd, l1_s2_rd, l2_s1_rd, l2_s2_rd;
  logic          l1_s1_v, l1_s2_v, l2_s1_v, l2_s2_v;
  logic          l1_wait, l1_busy, l1_done, l2_wait, l2_busy, l2_done;

  dual_port_frame_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(rst_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_readdata(l1_s1_rd), .s1_readdatavalid(l1_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_byteenable(s2_byteenable),
    .s2_readdata(l1_s2_rd), .s2_readdatavalid(l1_s2_v), .s2_waitrequest(l1_wait),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(l1_busy), .fill_done(l1_done)
  );

  dual_port_frame_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .reset_n(rst_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_readdata(l2_s1_rd), .s1_readdatavalid(l2_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_byteenable(s2_byteenable),
    .s2_readdata(l2_s2_rd), .s2_readdatavalid(l2_s2_v), .s2_waitrequest(l2_wait),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(l2_busy), .fill_done(l2_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  int cyc;
  int busy_seen;
  int done_seen;

  // Reference model: word array, fill schedule by start cycle, expected read beats
  logic [DW-1:0] mm [DP];
  bit            fill_on;
  int            base;
  logic [DW-1:0] fval;
  bit            x1_v1, x1_v2, x2_v1, x2_v2;
  logic [DW-1:0] x1_d1, x1_d2, x2_d1, x2_d2;

  task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
  endtask

  // Fill owns port 2 from the cycle after start through the done cycle
  function automatic bit in_window(input int c);
    return fill_on && (c >= base + 1) && (c <= base + int'(DP) + 1);
  endfunction

  task automatic mem_write(input logic [3:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    for (int i = 0; i < int'(BW); i++)
      if (be[i]) mm[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic model_cycle();
    bit            wait_now, r1, r2, w1, w2;
    logic [DW-1:0] d1, d2, wd2;
    logic [3:0]    wa2;
    logic [BW-1:0] wbe2;
    wait_now = in_window(cyc);
    r1 = s1_chipselect && s1_read && !s1_write;
    r2 = s2_chipselect && s2_read && !s2_write && !wait_now;
    d1 = (r1 && s1_address < 5'(DP)) ? mm[s1_address[3:0]] : '0;
    d2 = (r2 && s2_address < 5'(DP)) ? mm[s2_address[3:0]] : '0;
    x1_v2 = x1_v1; x1_d2 = x1_d1; x1_v1 = r1; x1_d1 = d1;
    x2_v2 = x2_v1; x2_d2 = x2_d1; x2_v1 = r2; x2_d1 = d2;
    w1 = s1_chipselect && s1_write && s1_address < 5'(DP);
    w2 = 0; wa2 = '0; wd2 = '0; wbe2 = '0;
    if (wait_now) begin
      if (cyc - base - 1 < int'(DP)) begin
        w2 = 1; wa2 = 4'(cyc - base - 1); wd2 = fval; wbe2 = '1;
      end
    end else if (s2_chipselect && s2_write && s2_address < 5'(DP)) begin
      w2 = 1; wa2 = s2_address[3:0]; wd2 = s2_writedata; wbe2 = s2_byteenable;
    end
    if (w2 && !(w1 && s1_address[3:0] == wa2)) mem_write(wa2, wd2, wbe2);
    if (w1) mem_write(s1_address[3:0], s1_writedata, s1_byteenable);
    if (!wait_now && fill_start) begin
      fill_on = 1; base = cyc; fval = fill_value;
    end
  endtask

  task automatic check_cycle();
    bit eb, ed;
    eb = in_window(cyc);
    ed = fill_on && (cyc == base + int'(DP) + 1);
    if (l1_busy) busy_seen++;
    if (l1_done) done_seen++;
    chk1("l1_busy", l1_busy, eb);
    chk1("l1_wait", l1_wait, eb);
    chk1("l1_done", l1_done, ed);
    chk1("l2_busy", l2_busy, eb);
    chk1("l2_wait", l2_wait, eb);
    chk1("l2_done", l2_done, ed);
    chk1("l1_s1_valid", l1_s1_v, x1_v1);
    if (x1_v1) chk32("l1_s1_data", l1_s1_rd, x1_d1);
    chk1("l1_s2_valid", l1_s2_v, x2_v1);
    if (x2_v1) chk32("l1_s2_data", l1_s2_rd, x2_d1);
    chk1("l2_s1_valid", l2_s1_v, x1_v2);
    if (x1_v2) chk32("l2_s1_data", l2_s1_rd, x1_d2);
    chk1("l2_s2_valid", l2_s2_v, x2_v2);
    if (x2_v2) chk32("l2_s2_data", l2_s2_rd, x2_d2);
  endtask

  task automatic step();
    if (rst_n) model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk32({tag, "_l1_s1_rd"}, l1_s1_rd, '0);
    chk32({tag, "_l1_s2_rd"}, l1_s2_rd, '0);
    chk32({tag, "_l2_s1_rd"}, l2_s1_rd, '0);
    chk32({tag, "_l2_s2_rd"}, l2_s2_rd, '0);
    chk1({tag, "_l1_s1_v"}, l1_s1_v, 1'b0);
    chk1({tag, "_l1_s2_v"}, l1_s2_v, 1'b0);
    chk1({tag, "_l2_s1_v"}, l2_s1_v, 1'b0);
    chk1({tag, "_l2_s2_v"}, l2_s2_v, 1'b0);
    chk1({tag, "_l1_wait"}, l1_wait, 1'b0);
    chk1({tag, "_l1_busy"}, l1_busy, 1'b0);
    chk1({tag, "_l1_done"}, l1_done, 1'b0);
    chk1({tag, "_l2_busy"}, l2_busy, 1'b0);
    chk1({tag, "_l2_done"}, l2_done, 1'b0);
  endtask

  task automatic idle_inputs();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_writedata = '0; s1_byteenable = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_writedata = '0; s2_byteenable = '0;
    fill_start = 0; fill_value = '0;
  endtask

  task automatic drv1(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
    s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic drv2(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
    s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  task automatic model_reset();
    fill_on = 0;
    x1_v1 = 0; x1_v2 = 0; x2_v1 = 0; x2_v2 = 0;
    x1_d1 = '0; x1_d2 = '0; x2_d1 = '0; x2_d2 = '0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; busy_seen = 0; done_seen = 0;
    base = 0; fval = '0;
    model_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;

    // Byte-enable merge, read back through port 2 at both latencies
    drv1(0, 1, 5'd5, 32'hAABBCCDD, 4'hF); step();
    drv1(0, 1, 5'd5, 32'h11223344, 4'h5); step();
    idle_inputs(); drv2(1, 0, 5'd5, '0, '0); step();
    chk32("be_lat1", l1_s2_rd, 32'hAA22CC44);
    idle_inputs(); step();
    chk32("be_lat2", l2_s2_rd, 32'hAA22CC44);

    // Same-address write collision: port 1 wins
    drv1(0, 1, 5'd10, 32'h12, 4'hF); drv2(0, 1, 5'd10, 32'h34, 4'hF); step();
    idle_inputs(); drv2(1, 0, 5'd10, '0, '0); step();
    chk32("collision", l1_s2_rd, 32'h12);

    // Mixed-port read-during-write returns old data
    idle_inputs(); drv1(0, 1, 5'd7, 32'h55, 4'hF); step();
    drv1(0, 1, 5'd7, 32'h66, 4'hF); drv2(1, 0, 5'd7, '0, '0); step();
    chk32("rdw_old", l1_s2_rd, 32'h55);
    idle_inputs(); drv2(1, 0, 5'd7, '0, '0); step();
    chk32("rdw_new", l1_s2_rd, 32'h66);
    idle_inputs(); step(); step();

    // Full fill with port 2 read in flight at start and port 1 traffic during fill
    busy_seen = 0; done_seen = 0;
    fill_start = 1; fill_value = 32'h3C; drv2(1, 0, 5'd5, '0, '0); step();
    for (int i = 1; i <= int'(DP) + 3; i++) begin
      idle_inputs();
      case (i)
        3:  drv2(1, 0, 5'd9, '0, '0);
        6:  drv1(0, 1, 5'd5, 32'h99, 4'hF);
        7:  drv1(1, 0, 5'd0, '0, '0);
        10: drv2(0, 1, 5'd3, 32'hDEAD, 4'hF);
        default: ;
      endcase
      step();
      if (i == 7) chk32("fill_p1_rd0", l1_s1_rd, 32'h3C);
    end
    chk32("fill_busy_cycles", 32'(busy_seen), 32'd17);
    chk32("fill_done_pulses", 32'(done_seen), 32'd1);
    for (int a = 0; a < int'(DP); a++) begin
      idle_inputs(); drv2(1, 0, 5'(a), '0, '0); step();
      chk32("fill_readback", l1_s2_rd, (a == 5) ? 32'h99 : 32'h3C);
    end
    idle_inputs(); step();

    // Reset in the cycle the fill would write address 8, with a read beat in flight
    fill_start = 1; fill_value = 32'hA5; step();
    for (int i = 1; i <= 8; i++) begin
      idle_inputs();
      if (i == 8) drv1(1, 0, 5'd2, '0, '0);
      step();
    end
    rst_n = 0;
    #1;
    chk_zero("rst_mid_fill");
    model_reset();
    idle_inputs(); step(); step();
    rst_n = 1;
    for (int a = 0; a < int'(DP); a++) begin
      idle_inputs(); drv2(1, 0, 5'(a), '0, '0); step();
      chk32("rst_readback", l1_s2_rd, (a < 8) ? 32'hA5 : 32'h3C);
    end

    // Out-of-range write discarded, out-of-range reads return zero with valid
    idle_inputs(); drv1(0, 1, 5'd16, 32'hFFFFFFFF, 4'hF); step();
    idle_inputs(); drv1(1, 0, 5'd16, '0, '0); drv2(1, 0, 5'd16, '0, '0); step();
    chk1("oor_s1_valid", l1_s1_v, 1'b1);
    chk32("oor_s1_data", l1_s1_rd, 32'h0);
    chk1("oor_s2_valid", l1_s2_v, 1'b1);
    chk32("oor_s2_data", l1_s2_rd, 32'h0);
    idle_inputs(); drv2(1, 0, 5'd0, '0, '0); step();
    chk32("oor_no_alias", l1_s2_rd, 32'hA5);

    // Randomized traffic on both ports with occasional fills
    for (int n = 0; n < 400; n++) begin
      s1_chipselect = ($urandom_range(0, 3) != 0);
      s1_read       = 1'($urandom_range(0, 1));
      s1_write      = 1'($urandom_range(0, 1));
      s1_address    = 5'($urandom_range(0, 17));
      s1_writedata  = $urandom;
      s1_byteenable = 4'($urandom_range(0, 15));
      s2_chipselect = ($urandom_range(0, 3) != 0);
      s2_read       = 1'($urandom_range(0, 1));
      s2_write      = 1'($urandom_range(0, 1));
      s2_address    = 5'($urandom_range(0, 17));
      s2_writedata  = $urandom;
      s2_byteenable = 4'($urandom_range(0, 15));
      fill_start    = ($urandom_range(0, 63) == 0);
      fill_value    = $urandom;
      step();
    end
    idle_inputs();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
